// File: rtl/tppe_pkg.sv
// Shared TPPE types: default sizes, the partial-sum transmitter
// state encoding and a saturating Q-bit adder.
package tppe_pkg;

  localparam int DEF_T = 16;
  localparam int DEF_Q = 10;

  typedef enum logic [1:0] {
    ACCUM,
    ISSUE,
    WAIT
  } state_t;

  function automatic logic [DEF_Q-1:0] sat_add(
    input logic [DEF_Q-1:0] a,
    input logic [DEF_Q-1:0] b
  );
    logic [DEF_Q:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DEF_Q] ? {DEF_Q{1'b1}} : s[DEF_Q-1:0];
  endfunction

endpackage

// File: rtl/psum_lane.sv
// One timestep's saturating partial-sum register.
// Ports: en/spike gate the add of weight, clr zeroes, sat flags a clamp.
module psum_lane #(
  parameter int Q = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         spike,
  input  logic [Q-1:0] weight,
  input  logic         clr,
  output logic [Q-1:0] sum,
  output logic         sat
);

  logic [Q:0] raw;

  assign raw = {1'b0, sum} + {1'b0, weight};
  assign sat = en & spike & raw[Q];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sum <= '0;
    end else if (en && spike) begin
      sum <= raw[Q] ? {Q{1'b1}} : raw[Q-1:0];
    end
  end

endmodule

// File: rtl/spike_psum_tx.sv
// Accumulates (spike-train, weight) beats into T partial sums and hands
// them to the LIF neuron via result_val/start, holding until lif_done.
// Ports: in_* beat stream, result_val/start/input_data/sat_flag/len_err
// toward the neuron, lif_done back from it.
module spike_psum_tx
  import tppe_pkg::*;
#(
  parameter int T         = DEF_T,
  parameter int Q         = DEF_Q,
  parameter int MAX_BEATS = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [T-1:0]   in_spikes,
  input  logic [Q-1:0]   in_weight,
  input  logic           in_last,
  output logic           result_val,
  output logic           start,
  output logic [T*Q-1:0] input_data,
  input  logic           lif_done,
  output logic           sat_flag,
  output logic           len_err
);

  localparam int CW = $clog2(MAX_BEATS) + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [T-1:0]  sat_v;
  logic          accept;
  logic          close;
  logic          clr;

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid & in_ready;
  assign cnt_nx   = cnt + 1'b1;
  assign close    = in_last | (cnt_nx == CW'(MAX_BEATS));
  assign clr      = (state == WAIT) & lif_done;

  for (genvar t = 0; t < T; t++) begin : g_lane
    psum_lane #(.Q(Q)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (accept),
      .spike  (in_spikes[t]),
      .weight (in_weight),
      .clr    (clr),
      .sum    (input_data[(t+1)*Q-1 -: Q]),
      .sat    (sat_v[t])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACCUM;
      cnt        <= '0;
      result_val <= 1'b0;
      start      <= 1'b0;
      sat_flag   <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            cnt      <= cnt_nx;
            sat_flag <= sat_flag | (|sat_v);
            if (close) begin
              state      <= ISSUE;
              result_val <= 1'b1;
              start      <= 1'b1;
              // force-closed at the beat limit
              len_err    <= ~in_last;
            end
          end
        end
        ISSUE: begin
          start <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (lif_done) begin
            state      <= ACCUM;
            cnt        <= '0;
            sat_flag   <= 1'b0;
            len_err    <= 1'b0;
            result_val <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_psum_tx.sv
// Randomized self-checking bench for spike_psum_tx against a
// per-timestep saturating-sum reference model.
module tb_spike_psum_tx;

  localparam int T  = 16;
  localparam int Q  = 10;
  localparam int MB = 4;
  localparam int QM = (1 << Q) - 1;

  logic           clk = 0;
  logic           rst_n = 0;
  logic           in_valid = 0;
  logic           in_ready;
  logic [T-1:0]   in_spikes = '0;
  logic [Q-1:0]   in_weight = '0;
  logic           in_last = 0;
  logic           result_val;
  logic           start;
  logic [T*Q-1:0] input_data;
  logic           lif_done = 0;
  logic           sat_flag;
  logic           len_err;

  int n_chk = 0;
  int n_err = 0;

  int es[T];
  bit esat;

  always #5 clk = ~clk;

  spike_psum_tx #(.T(T), .Q(Q), .MAX_BEATS(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_spikes  (in_spikes),
    .in_weight  (in_weight),
    .in_last    (in_last),
    .result_val (result_val),
    .start      (start),
    .input_data (input_data),
    .lif_done   (lif_done),
    .sat_flag   (sat_flag),
    .len_err    (len_err)
  );

  task automatic check(input string tag,
                       input logic [T*Q-1:0] got,
                       input logic [T*Q-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < T; i++) es[i] = 0;
    esat = 0;
  endtask

  task automatic model_beat(input logic [T-1:0] sp, input int w);
    for (int i = 0; i < T; i++) begin
      if (sp[i]) begin
        es[i] = es[i] + w;
        if (es[i] > QM) begin
          es[i] = QM;
          esat = 1;
        end
      end
    end
  endtask

  function automatic logic [T*Q-1:0] model_vec();
    logic [T*Q-1:0] v;
    v = '0;
    for (int i = 0; i < T; i++) v[i*Q +: Q] = Q'(es[i]);
    return v;
  endfunction

  // drive one beat from a negedge; returns at the negedge after acceptance
  task automatic beat(input logic [T-1:0] sp, input int w, input bit lst);
    int n;
    in_valid  = 1;
    in_spikes = sp;
    in_weight = Q'(w);
    in_last   = lst;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("beat_timeout", 0, 1);
    @(negedge clk);
    model_beat(sp, w);
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic check_issue(input bit elen, input bit spur);
    logic [T*Q-1:0] v;
    v = model_vec();
    check("issue_start", start, 1);
    check("issue_rv", result_val, 1);
    check("issue_rdy", in_ready, 0);
    check("issue_data", input_data, v);
    check("issue_sat", sat_flag, esat);
    check("issue_len", len_err, elen);
    if (spur) lif_done = 1;
    @(negedge clk);
    lif_done = 0;
    check("wait_start", start, 0);
    check("wait_rv", result_val, 1);
    check("wait_data", input_data, v);
    check("wait_len", len_err, elen);
  endtask

  task automatic finish_frame(input int hold);
    for (int i = 0; i < hold; i++) @(negedge clk);
    check("hold_rv", result_val, 1);
    lif_done = 1;
    @(negedge clk);
    lif_done = 0;
    model_clear();
    check("done_rv", result_val, 0);
    check("done_rdy", in_ready, 1);
    check("done_data", input_data, 0);
    check("done_flags", {sat_flag, len_err}, 0);
  endtask

  initial begin
    logic [T*Q-1:0] held;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    check("rst_rdy", in_ready, 1);
    check("rst_rv", {result_val, start}, 0);
    check("rst_data", input_data, 0);
    check("rst_flags", {sat_flag, len_err}, 0);

    // directed three-beat frame
    beat(16'h0001, 5, 0);
    check("mid_start", start, 0);
    beat(16'h8001, 7, 0);
    beat(16'hFFFF, 2, 1);
    check("d_sum0", input_data[9:0], 14);
    check("d_sum15", input_data[159:150], 9);
    check("d_sum1", input_data[19:10], 2);
    check_issue(0, 0);
    finish_frame(3);

    // saturation
    for (int i = 0; i < 4; i++) beat(16'h0004, 300, i == 3);
    check("s_sum2", input_data[29:20], 1023);
    check("s_sat", sat_flag, 1);
    check_issue(0, 0);
    finish_frame(1);

    // backpressure: a beat held valid across ISSUE/WAIT
    beat(16'h00F0, 9, 1);
    check_issue(0, 1);
    held = input_data;
    in_valid  = 1;
    in_spikes = 16'hFFFF;
    in_weight = 10'd1;
    in_last   = 1;
    for (int i = 0; i < 20; i++) begin
      check("bp_rdy", in_ready, 0);
      check("bp_data", input_data, held);
      @(negedge clk);
    end
    lif_done = 1;
    @(negedge clk);
    lif_done = 0;
    model_clear();
    check("bp_open", in_ready, 1);
    check("bp_clear", input_data, 0);
    @(negedge clk);
    model_beat(16'hFFFF, 1);
    in_valid = 0;
    in_last  = 0;
    check_issue(0, 0);
    finish_frame(0);

    // beat limit without in_last
    for (int i = 0; i < 4; i++) beat(T'($urandom), 3, 0);
    check_issue(1, 0);
    finish_frame(2);
    beat(16'h1234, 4, 1);
    check_issue(0, 0);
    finish_frame(0);

    // reset while waiting on the neuron
    beat(16'hA5A5, 17, 1);
    check_issue(0, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_clear();
    check("mr_rv", {result_val, start}, 0);
    check("mr_data", input_data, 0);
    check("mr_rdy", in_ready, 1);
    lif_done = 1;
    @(negedge clk);
    lif_done = 0;
    check("stale_done", {in_ready, result_val}, 2'b10);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int nb;
      bit lst;
      bit elen;
      nb   = $urandom_range(1, MB);
      elen = 0;
      for (int b = 0; b < nb; b++) begin
        int w;
        w = $urandom_range(0, 1) ? $urandom_range(0, 40)
                                 : $urandom_range(0, QM);
        lst = (b == nb - 1);
        if (b == MB - 1) begin
          lst  = $urandom_range(0, 1);
          elen = !lst;
        end
        beat(T'($urandom), w, lst);
      end
      check_issue(elen, $urandom_range(0, 1));
      finish_frame($urandom_range(0, 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
